// File: rtl/disaggregator.sv
// Splits one wide word from a valid/deq source into FETCH_WIDTH narrow slices,
// LSB slice first, pushed into a narrow FIFO write port at one slice per cycle.
module disaggregator #(
    parameter int DATA_WIDTH  = 11,
    parameter int FETCH_WIDTH = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              wrst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    output logic                              busy,
    output logic [COUNT_WIDTH-1:0]            words_done
);

    localparam int IDX_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       buf_q, buf_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [COUNT_WIDTH-1:0]  words_done_q, words_done_d;
    logic                    last;
    logic [DATA_WIDTH-1:0]   slice_w [FETCH_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slice
            assign slice_w[gi] = buf_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        receiver_data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                receiver_data = slice_w[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            idx_q        <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;

        last         = (idx_q == LAST_IDX);
        receiver_enq = wrst_n && (state_q == SEND) && receiver_full_n;
        // Refill on the last enqueue so back-to-back words leave no bubble.
        sender_deq   = wrst_n && sender_empty_n &&
                       ((state_q == IDLE) || (receiver_enq && last));

        if (receiver_enq) begin
            if (!last) begin
                idx_d = idx_q + IDX_W'(1);
            end else begin
                words_done_d = words_done_q + COUNT_WIDTH'(1);
                state_d      = IDLE;
                idx_d        = '0;
            end
        end

        if (sender_deq) begin
            buf_d   = sender_data;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    assign busy       = (state_q == SEND);
    assign words_done = words_done_q;

endmodule
